// File: rtl/datapath_sequencer_pkg.sv
// Shared opcodes, T-state encoding and the strobe bundle for the DataPath sequencer.
package cpu_ctrl_pkg;

    localparam int DEF_IMM_W = 8;

    typedef enum logic [1:0] {
        OP_LDA   = 2'b00,
        OP_ADDI  = 2'b01,
        OP_MVAB  = 2'b10,
        OP_LDADD = 2'b11
    } opcode_e;

    // Three bits leave spare encodings; the sequencer sends any of them back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3
    } state_e;

    typedef struct packed {
        logic ra_in;
        logic rb_in;
        logic rz_in;
        logic ra_out;
        logic rb_out;
        logic rz_out;
    } strobe_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus DataPath strobe bundle; slave is the sequencer, master the issuer.
interface datapath_sequencer_if #(parameter int IMM_W = 8);

    logic             instr_valid;
    logic             instr_ready;
    logic [1:0]       opcode;
    logic [IMM_W-1:0] imm;

    logic             RAin, RBin, RZin;
    logic             RAout, RBout, RZout;
    logic [IMM_W-1:0] AddImmediate;
    logic [IMM_W-1:0] RegisterAImmediate;
    logic             busy;
    logic             done;

    modport slave (
        input  instr_valid, opcode, imm,
        output instr_ready, RAin, RBin, RZin, RAout, RBout, RZout,
               AddImmediate, RegisterAImmediate, busy, done
    );

    modport master (
        output instr_valid, opcode, imm,
        input  instr_ready, RAin, RBin, RZin, RAout, RBout, RZout,
               AddImmediate, RegisterAImmediate, busy, done
    );

endinterface

// File: rtl/seq_step_decode.sv
// Combinational step table: (state, opcode, imm) -> strobes, immediates and last-step flag.
module seq_step_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W
) (
    input  state_e           state,
    input  opcode_e          opcode,
    input  logic [IMM_W-1:0] imm,
    output strobe_t          strobes,
    output logic [IMM_W-1:0] add_imm,
    output logic [IMM_W-1:0] rega_imm,
    output logic             last_step
);

    always_comb begin
        strobes   = '0;
        add_imm   = '0;
        rega_imm  = '0;
        last_step = 1'b0;
        case (state)
            ST_T0: begin
                case (opcode)
                    OP_LDA: begin
                        rega_imm      = imm;
                        strobes.ra_in = 1'b1;
                        last_step     = 1'b1;
                    end
                    OP_ADDI: begin
                        strobes.ra_out = 1'b1;
                        strobes.rz_in  = 1'b1;
                        add_imm        = imm;
                    end
                    OP_MVAB: begin
                        strobes.rb_out = 1'b1;
                        strobes.ra_in  = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_LDADD: begin
                        rega_imm      = imm;
                        strobes.ra_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T1: begin
                case (opcode)
                    OP_ADDI: begin
                        strobes.rz_out = 1'b1;
                        strobes.rb_in  = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_LDADD: begin
                        strobes.ra_out = 1'b1;
                        strobes.rz_in  = 1'b1;
                        add_imm        = imm;
                    end
                    // single-step opcodes never reach T1; finish so the FSM returns to IDLE
                    default: last_step = 1'b1;
                endcase
            end
            ST_T2: begin
                if (opcode == OP_LDADD) begin
                    strobes.rz_out = 1'b1;
                    strobes.rb_in  = 1'b1;
                end
                last_step = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Hardwired DataPath control sequencer: accepts one micro-instruction, walks T0..T2.
// Optional SEQ_HOLD_EN adds a hold input that freezes and blanks the current step.
module datapath_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W
) (
    input  logic                 clock,
    input  logic                 clear_n,
`ifdef SEQ_HOLD_EN
    input  logic                 hold,
`endif
    datapath_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    opcode_e          op_q, op_d;
    logic [IMM_W-1:0] imm_q, imm_d;

    strobe_t          stb;
    logic [IMM_W-1:0] add_imm, rega_imm;
    logic             last_step;
    logic             hold_w;
    logic             in_step;
    logic             gate;

`ifdef SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    seq_step_decode #(.IMM_W(IMM_W)) u_dec (
        .state     (state_q),
        .opcode    (op_q),
        .imm       (imm_q),
        .strobes   (stb),
        .add_imm   (add_imm),
        .rega_imm  (rega_imm),
        .last_step (last_step)
    );

    assign in_step = (state_q == ST_T0) || (state_q == ST_T1) || (state_q == ST_T2);
    assign gate    = in_step && !hold_w;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && bus.instr_ready) begin
                    state_d = ST_T0;
                    op_d    = opcode_e'(bus.opcode);
                    imm_d   = bus.imm;
                end
            end
            ST_T0: if (!hold_w) state_d = last_step ? ST_IDLE : ST_T1;
            ST_T1: if (!hold_w) state_d = last_step ? ST_IDLE : ST_T2;
            ST_T2: if (!hold_w) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LDA;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
        end
    end

    // Everything below depends only on registered state, so reset blanks it immediately.
    assign bus.instr_ready        = (state_q == ST_IDLE) && !hold_w;
    assign bus.busy               = in_step;
    assign bus.done               = gate && last_step;
    assign bus.RAin               = gate && stb.ra_in;
    assign bus.RBin               = gate && stb.rb_in;
    assign bus.RZin               = gate && stb.rz_in;
    assign bus.RAout              = gate && stb.ra_out;
    assign bus.RBout              = gate && stb.rb_out;
    assign bus.RZout              = gate && stb.rz_out;
    assign bus.AddImmediate       = gate ? add_imm  : '0;
    assign bus.RegisterAImmediate = gate ? rega_imm : '0;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Random + directed bench for datapath_sequencer against a queue-of-steps model and a tiny DataPath model.
module tb_datapath_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int IMM_W = 8;
    localparam logic [5:0] S_RAIN  = 6'b100000;
    localparam logic [5:0] S_RBIN  = 6'b010000;
    localparam logic [5:0] S_RZIN  = 6'b001000;
    localparam logic [5:0] S_RAOUT = 6'b000100;
    localparam logic [5:0] S_RBOUT = 6'b000010;
    localparam logic [5:0] S_RZOUT = 6'b000001;

    typedef logic [24:0] vec_t;  // {ready, busy, done, strobes[5:0], add[7:0], rega[7:0]}

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    logic hold = 1'b0;

    always #5 clock = ~clock;

    datapath_sequencer_if #(.IMM_W(IMM_W)) dif ();

    datapath_sequencer #(.IMM_W(IMM_W)) dut (
        .clock   (clock),
        .clear_n (clear_n),
`ifdef SEQ_HOLD_EN
        .hold    (hold),
`endif
        .bus     (dif)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   accepted = 0;
    int   done_cnt = 0;
    vec_t q[$];
    logic [7:0] ra = '0, rb = '0, rz = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rdy, bit bsy, bit dn, logic [5:0] s, logic [7:0] add, logic [7:0] rega);
        return {rdy, bsy, dn, s, add, rega};
    endfunction

    function automatic vec_t obs();
        return {dif.instr_ready, dif.busy, dif.done, dif.RAin, dif.RBin, dif.RZin,
                dif.RAout, dif.RBout, dif.RZout, dif.AddImmediate, dif.RegisterAImmediate};
    endfunction

    // One queue entry per clock the instruction occupies; done marks its last entry.
    task automatic push_instr(input logic [1:0] op, input logic [7:0] im);
        case (op)
            2'b00: q.push_back(mk(0, 1, 1, S_RAIN, 8'h00, im));
            2'b01: begin
                q.push_back(mk(0, 1, 0, S_RAOUT | S_RZIN, im, 8'h00));
                q.push_back(mk(0, 1, 1, S_RZOUT | S_RBIN, 8'h00, 8'h00));
            end
            2'b10: q.push_back(mk(0, 1, 1, S_RBOUT | S_RAIN, 8'h00, 8'h00));
            default: begin
                q.push_back(mk(0, 1, 0, S_RAIN, 8'h00, im));
                q.push_back(mk(0, 1, 0, S_RAOUT | S_RZIN, im, 8'h00));
                q.push_back(mk(0, 1, 1, S_RZOUT | S_RBIN, 8'h00, 8'h00));
            end
        endcase
        accepted++;
    endtask

    task automatic step(input bit v, input logic [1:0] op, input logic [7:0] im, input bit h);
        vec_t exp;
        bit   idle;
        logic [7:0] bus_v, na, nb, nz;
        @(negedge clock);
        dif.instr_valid = v;
        dif.opcode      = op;
        dif.imm         = im;
        hold            = h;
        #1;
        idle = (q.size() == 0);
        if (idle)   exp = mk(!h, 0, 0, 6'b0, 8'h00, 8'h00);
        else if (h) exp = mk(0, 1, 0, 6'b0, 8'h00, 8'h00);
        else        exp = q.pop_front();
        chk("outputs", 32'(obs()), 32'(exp));
        chk("bus_onehot", 32'(($countones({dif.RAout, dif.RBout, dif.RZout}) <= 1) ? 1 : 0), 32'd1);
        if (dif.done) done_cnt++;
        bus_v = dif.RAout ? ra : dif.RBout ? rb : dif.RZout ? rz : 8'h00;
        na = dif.RAin ? (bus_v | dif.RegisterAImmediate) : ra;
        nb = dif.RBin ? bus_v : rb;
        nz = dif.RZin ? 8'(bus_v + dif.AddImmediate) : rz;
        ra = na; rb = nb; rz = nz;
        if (idle && v && !h) push_instr(op, im);
    endtask

    initial begin
        int d0, target, cyc;
        bit h;
        dif.instr_valid = 1'b0;
        dif.opcode      = 2'b00;
        dif.imm         = 8'h00;

        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_outputs", 32'(obs() & 25'h0FF_FFFF), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        #1;
        chk("rst_ready", 32'(dif.instr_ready), 32'd1);

        // LDA 05: one step, done in it, then IDLE
        step(1, 2'b00, 8'h05, 0);
        step(0, 2'b00, 8'h00, 0);
        step(0, 2'b00, 8'h00, 0);
        chk("lda_A", 32'(ra), 32'h05);

        // LDADD 05: B ends up 05 + 05
        step(1, 2'b11, 8'h05, 0);
        repeat (4) step(0, 2'b00, 8'h00, 0);
        chk("ldadd_B", 32'(rb), 32'h0A);

        // ADDI then MVAB with valid held: MVAB waits for the IDLE after ADDI's T1
        d0 = done_cnt;
        step(1, 2'b01, 8'h11, 0);
        step(1, 2'b10, 8'h33, 0);
        step(1, 2'b10, 8'h33, 0);
        step(1, 2'b10, 8'h33, 0);
        step(0, 2'b00, 8'h00, 0);
        step(0, 2'b00, 8'h00, 0);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);
        chk("mvab_A", 32'(ra), 32'(rb));

        // Reset in the middle of ADDI T1 abandons it
        step(1, 2'b01, 8'h21, 0);
        step(0, 2'b00, 8'h00, 0);
        @(posedge clock);
        #1;
        chk("addi_t1", 32'({dif.RZout, dif.RBin}), 32'd3);
        clear_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'(obs() & 25'h0FF_FFFF), 32'd0);
        chk("rst_mid_done", 32'(dif.done), 32'd0);
        q.delete();
        accepted--;
        #1 clear_n = 1'b1;
        step(0, 2'b00, 8'h00, 0);

`ifdef SEQ_HOLD_EN
        // Hold three cycles in LDADD T1, then T1 is reissued in full
        step(1, 2'b11, 8'h05, 0);
        step(0, 2'b00, 8'h00, 0);
        repeat (3) step(0, 2'b00, 8'h00, 1);
        step(0, 2'b00, 8'h00, 0);
        step(0, 2'b00, 8'h00, 0);
        step(0, 2'b00, 8'h00, 1);
        step(0, 2'b00, 8'h00, 0);
        chk("hold_ldadd_B", 32'(rb), 32'h0A);
`endif

        // Random stream of 1000 instructions with random valid gaps
        target = accepted + 1000;
        cyc = 0;
        while (accepted < target && cyc < 20000) begin
            h = 1'b0;
`ifdef SEQ_HOLD_EN
            h = ($urandom_range(0, 9) == 0);
`endif
            step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), 8'($urandom), h);
            cyc++;
        end
        chk("rand_accepted", 32'(accepted), 32'(target));
        repeat (4) step(0, 2'b00, 8'h00, 0);
        chk("done_vs_accepted", 32'(done_cnt), 32'(accepted));
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
